// File: rtl/jtag_cmd_exec.sv
// jtag_cmd_exec: executes TAP-issued opcodes as single bus transactions.
// Optional bus timeout is compiled in by defining JTAG_CMD_TIMEOUT_EN.
module jtag_cmd_exec #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              tck,
  input  logic              trst,
  input  logic [7:0]        userOp,
  input  logic              userOp_ready,
  input  logic [DATA_W-1:0] userData_out,
  output logic [DATA_W-1:0] userData_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_SETADDR   = 8'h01;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRITE_INC = 8'h04;
  localparam logic [7:0] OP_READ_INC  = 8'h05;
  localparam logic [7:0] OP_STATUS    = 8'h06;
  localparam logic [7:0] OP_CLRERR    = 8'h07;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ready_p1;
  logic              accept;
  logic              bus_op;
  logic              cmd_inc;
  logic              ovr;
  logic              timeout_seen;
  logic              tmo_hit;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] status_word;

  // Stage p0 -> p1: opcode strobe edge detect
  assign accept = userOp_ready & ~ready_p1;
  assign bus_op = (userOp >= OP_WRITE) && (userOp <= OP_READ_INC);

  always_comb begin
    status_word = '0;
    status_word[DATA_W-1:DATA_W-4] = {busy, err, ovr, timeout_seen};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && bus_op) state_nxt = BUS;
      BUS:     if (bus_ack || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bus_req/busy are flopped from the next state so they never glitch on
  // the two-bit BUS->DONE transition.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state    <= IDLE;
      ready_p1 <= 1'b0;
      bus_req  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_p1 <= userOp_ready;
      bus_req  <= (state_nxt == BUS);
      busy     <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      addr        <= '0;
      bus_addr    <= '0;
      bus_we      <= 1'b0;
      bus_wdata   <= '0;
      userData_in <= '0;
      cmd_inc     <= 1'b0;
      err         <= 1'b0;
      ovr         <= 1'b0;
    end else begin
      if (accept) begin
        if (state != IDLE) begin
          ovr <= 1'b1;
        end else begin
          case (userOp)
            OP_NOP: ;
            OP_SETADDR: addr <= userData_out[ADDR_W-1:0];
            OP_WRITE, OP_WRITE_INC: begin
              bus_addr  <= addr;
              bus_we    <= 1'b1;
              bus_wdata <= userData_out;
              cmd_inc   <= (userOp == OP_WRITE_INC);
            end
            OP_READ, OP_READ_INC: begin
              bus_addr <= addr;
              bus_we   <= 1'b0;
              cmd_inc  <= (userOp == OP_READ_INC);
            end
            OP_STATUS: userData_in <= status_word;
            OP_CLRERR: begin
              err <= 1'b0;
              ovr <= 1'b0;
            end
            default: err <= 1'b1;
          endcase
        end
      end
      if (state == BUS) begin
        if (bus_ack) begin
          if (!bus_we) userData_in <= bus_rdata;
        end else if (tmo_hit) begin
          // an aborted transfer must not advance the address
          err     <= 1'b1;
          cmd_inc <= 1'b0;
        end
      end
      if (state == DONE && cmd_inc) begin
        addr <= addr + ADDR_W'(4);
      end
    end
  end

`ifdef JTAG_CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (state == BUS) && !bus_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      tmo_cnt      <= '0;
      timeout_seen <= 1'b0;
    end else begin
      if (state == BUS && !tmo_hit) tmo_cnt <= tmo_cnt + CNT_W'(1);
      else                          tmo_cnt <= '0;
      if (tmo_hit) timeout_seen <= 1'b1;
    end
  end
`else
  assign tmo_hit      = 1'b0;
  assign timeout_seen = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_cmd_exec.sv
// Bench for jtag_cmd_exec: transaction-level model plus per-cycle compare.
// Timeout checks are compiled only when JTAG_CMD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_jtag_cmd_exec;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 8;

  logic          tck;
  logic          trst;
  logic [7:0]    userOp;
  logic          userOp_ready;
  logic [DW-1:0] userData_out;
  logic [DW-1:0] userData_in;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic          busy;
  logic          err;

  jtag_cmd_exec #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .tck(tck), .trst(trst), .userOp(userOp), .userOp_ready(userOp_ready),
    .userData_out(userData_out), .userData_in(userData_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .err(err)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  bit            chk_on = 0;
  logic          exp_busy, exp_req, exp_err, exp_we, m_ovr, m_tmo, m_inc;
  logic [DW-1:0] exp_udi, exp_wdata;
  logic [AW-1:0] m_addr, exp_baddr;
  int            m_txn = 0;
  int            n_txn = 0;
  int            req_cycles = 0;
  logic          req_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge tck) begin
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("bus_req", 32'(bus_req), 32'(exp_req));
      chk("err", 32'(err), 32'(exp_err));
      chk("userData_in", userData_in, exp_udi);
      if (exp_req) begin
        chk("bus_addr", bus_addr, exp_baddr);
        chk("bus_we", 32'(bus_we), 32'(exp_we));
        if (exp_we) chk("bus_wdata", bus_wdata, exp_wdata);
      end
      if (bus_req && !req_prev) n_txn++;
      if (bus_req) req_cycles++;
    end
    req_prev = bus_req;
  end

  task automatic model_reset();
    exp_busy = 0; exp_req = 0; exp_err = 0; exp_we = 0;
    m_ovr = 0; m_tmo = 0; m_inc = 0;
    exp_udi = '0; exp_wdata = '0; m_addr = '0; exp_baddr = '0;
  endtask

  // effect of a command accepted while idle
  task automatic model_accept(input logic [7:0] op, input logic [DW-1:0] data);
    case (op)
      8'h00: ;
      8'h01: m_addr = data;
      8'h02, 8'h03, 8'h04, 8'h05: begin
        exp_req = 1; exp_busy = 1;
        exp_we = (op == 8'h02) || (op == 8'h04);
        exp_baddr = m_addr;
        if (exp_we) exp_wdata = data;
        m_inc = (op == 8'h04) || (op == 8'h05);
        m_txn++;
      end
      8'h06: exp_udi = {1'b0, exp_err, m_ovr, m_tmo, 28'h0};
      8'h07: begin exp_err = 0; m_ovr = 0; end
      default: exp_err = 1;
    endcase
  endtask

  task automatic issue(input logic [7:0] op, input logic [DW-1:0] data, input bit ack_too);
    @(posedge tck); #1;
    userOp = op; userData_out = data; userOp_ready = 1'b1;
    bus_ack = ack_too; bus_rdata = 32'hBAD0_0BAD;
    @(posedge tck); #1;
    userOp_ready = 1'b0; bus_ack = 1'b0;
    model_accept(op, data);
  endtask

  task automatic finish_bus(input int lat, input logic [DW-1:0] rd);
    repeat (lat) begin @(posedge tck); #1; end
    bus_ack = 1'b1; bus_rdata = rd;
    @(posedge tck); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    exp_req = 0;
    if (!exp_we) exp_udi = rd;
    @(posedge tck); #1;
    exp_busy = 0;
    if (m_inc) m_addr = m_addr + 32'd4;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    trst = 1'b0; userOp = 8'h0; userOp_ready = 1'b0; userData_out = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    model_reset();
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_udi", userData_in, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    @(posedge tck); @(posedge tck); #1;
    trst = 1'b1;
    chk_on = 1;

    // SETADDR 0x100 then WRITE
    issue(8'h01, 32'h100, 0);
    issue(8'h02, 32'hDEAD_BEEF, 0);
    chk("w_addr", bus_addr, 32'h100);
    chk("w_we", 32'(bus_we), 32'h1);
    chk("w_wdata", bus_wdata, 32'hDEAD_BEEF);
    finish_bus(0, 32'h0);
    chk("w_busy_after", 32'(busy), 32'h0);
    chk("w_err_after", 32'(err), 32'h0);

    // READ_INC twice from 0x200
    issue(8'h01, 32'h200, 0);
    issue(8'h05, 32'h0, 0);
    chk("ri1_addr", bus_addr, 32'h200);
    finish_bus(0, 32'h11);
    issue(8'h05, 32'h0, 0);
    chk("ri2_addr", bus_addr, 32'h204);
    finish_bus(1, 32'h22);
    chk("ri_udi", userData_in, 32'h22);
    issue(8'h02, 32'h1, 0);
    chk("ri_next_addr", bus_addr, 32'h208);
    finish_bus(0, 32'h0);

    // address wrap
    issue(8'h01, 32'hFFFF_FFFC, 0);
    issue(8'h04, 32'hA5, 0);
    finish_bus(2, 32'h0);
    issue(8'h03, 32'h0, 0);
    chk("wrap_addr", bus_addr, 32'h0);
    finish_bus(0, 32'h44);

    // illegal opcode, STATUS, CLRERR, NOP
    issue(8'h5A, 32'h0, 0);
    issue(8'h06, 32'h0, 0);
    chk("ill_status", userData_in, 32'h4000_0000);
    issue(8'h07, 32'h0, 0);
    issue(8'h00, 32'h0, 0);

    // bus_ack outside BUS is ignored
    @(posedge tck); #1; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge tck); #1; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(posedge tck); #1;

    // bus_ack coinciding with acceptance is ignored
    issue(8'h03, 32'h0, 1);
    finish_bus(2, 32'h33);

    // level strobe: only the first cycle is a command
    @(posedge tck); #1;
    userOp = 8'h01; userData_out = 32'h300; userOp_ready = 1'b1;
    @(posedge tck); #1;
    model_accept(8'h01, 32'h300);
    userOp = 8'h02; userData_out = 32'h999;
    @(posedge tck); #1;
    @(posedge tck); #1;
    userOp_ready = 1'b0;
    issue(8'h02, 32'h0BAD_F00D, 0);
    chk("lvl_addr", bus_addr, 32'h300);
    finish_bus(0, 32'h0);

    // overlapping command while stalled
    issue(8'h03, 32'h0, 0);
    @(posedge tck); #1;
    userOp = 8'h02; userData_out = 32'h5555_5555; userOp_ready = 1'b1;
    @(posedge tck); #1;
    userOp_ready = 1'b0; m_ovr = 1;
    finish_bus(1, 32'h77);
    issue(8'h06, 32'h0, 0);
    chk("ovr_status", userData_in, 32'h2000_0000);
    issue(8'h07, 32'h0, 0);

`ifdef JTAG_CMD_TIMEOUT_EN
    req_cycles = 0;
    issue(8'h05, 32'h0, 0);
    repeat (TMO - 1) begin @(posedge tck); #1; end
    @(posedge tck); #1;
    exp_req = 0; exp_err = 1; m_tmo = 1;
    @(posedge tck); #1;
    exp_busy = 0;
    chk("tmo_req_cycles", 32'(req_cycles), 32'd8);
    issue(8'h06, 32'h0, 0);
    chk("tmo_status", userData_in, 32'h5000_0000);
    issue(8'h07, 32'h0, 0);
    chk("tmo_clrerr", 32'(err), 32'h0);
    issue(8'h03, 32'h0, 0);
    chk("tmo_no_inc", bus_addr, 32'h300);
    finish_bus(0, 32'h66);
`else
    issue(8'h06, 32'h0, 0);
    chk("notmo_status", userData_in, 32'h0);
`endif

    // reset during BUS
    issue(8'h01, 32'h400, 0);
    issue(8'h05, 32'h0, 0);
    @(posedge tck); #1;
    @(posedge tck); #1;
    trst = 1'b0;
    #1;
    chk("rstbus_req", 32'(bus_req), 32'h0);
    chk("rstbus_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge tck); #1;
    trst = 1'b1;
    issue(8'h06, 32'h0, 0);
    chk("rstbus_status", userData_in, 32'h0);
    issue(8'h02, 32'h1234, 0);
    chk("rstbus_addr", bus_addr, 32'h0);
    finish_bus(0, 32'h0);

    @(posedge tck); #1;
    chk("txn_count", 32'(n_txn), 32'(m_txn));
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jtag_cmd_exec.md
JTAG_CMD_EXEC -- requirements
Module: jtag_cmd_exec

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports named tck and trst.
REQ-002 Parameter DATA_W, default 32: width of the user data and bus data paths.
REQ-003 Parameter ADDR_W, default 32: width of the bus address (ADDR_W <= DATA_W).
REQ-004 Parameter TIMEOUT_CYC, default 255: number of tck cycles to wait for bus_ack before aborting.
REQ-005 Ports, one per line (name, direction, width, meaning):
- tck  in  1  clock; every register is clocked on its rising edge.
- trst  in  1  asynchronous active-low reset.
- userOp  in  8  opcode from the TAP USEROP register.
- userOp_ready  in  1  opcode-update strobe from the TAP; may be a pulse or a level.
- userData_out  in  DATA_W  operand from the TAP USERDATA register.
- userData_in  out  DATA_W  capture value returned to the TAP USERDATA register.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  bus read data, valid when bus_ack = 1.
- bus_ack  in  1  bus completion.
- busy  out  1  a command is in progress.
- err  out  1  sticky error flag.

Function
REQ-006 Command acceptance: a command SHALL be accepted on the cycle in which userOp_ready is 1 and was 0 on the previous cycle (registered rising-edge detect); userOp and userData_out SHALL be sampled on that same cycle.
REQ-007 Opcodes SHALL be decoded as follows:
- 0x00 NOP.
- 0x01 SETADDR: addr <= userData_out[ADDR_W-1:0].
- 0x02 WRITE.
- 0x03 READ.
- 0x04 WRITE_INC.
- 0x05 READ_INC.
- 0x06 STATUS: userData_in <= status word.
- 0x07 CLRERR: clears err and ovr.
- Any other opcode: sets err; no bus activity.
REQ-008 FSM states SHALL be IDLE, BUS and DONE:
- IDLE -> BUS on an accepted bus opcode (0x02 to 0x05).
- BUS -> DONE on bus_ack = 1 or on timeout.
- DONE -> IDLE unconditionally after one cycle.
REQ-009 bus_req SHALL rise on the cycle after acceptance and remain 1 while in BUS.
- bus_addr, bus_we and bus_wdata SHALL be stable throughout BUS.
- bus_req SHALL drop on the cycle after bus_ack is sampled as 1.
REQ-010 READ and READ_INC SHALL capture bus_rdata into userData_in on the bus_ack cycle.
REQ-011 WRITE_INC and READ_INC SHALL increment addr by 4 in DONE; the increment SHALL wrap modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0x00000000.
REQ-012 busy SHALL be 1 from the cycle after acceptance through DONE inclusive.
REQ-013 Any opcode edge accepted while busy = 1 SHALL be dropped and SHALL set the ovr flag; the in-flight command SHALL be unaffected.
REQ-014 The status word SHALL be {busy, err, ovr, timeout_seen, 28'b0}.
REQ-015 bus_ack received outside BUS SHALL be ignored.
REQ-016 If acceptance and bus_ack occur in the same cycle while in IDLE, bus_ack SHALL be ignored.

Reset
REQ-017 While trst = 0, the block SHALL asynchronously force the following, and then leave reset on the first tck edge after trst rises:
- FSM = IDLE.
- bus_req, bus_we, busy, err = 0.
- ovr and timeout_seen = 0.
- addr, bus_addr, bus_wdata, userData_in = 0.
- edge-detect register = 0.
REQ-018 A reset asserted during BUS SHALL drop bus_req immediately, with no completion and no address increment.

Configuration
REQ-019 Feature macro: JTAG_CMD_TIMEOUT_EN.
- When defined: a counter SHALL run in BUS. When it reaches TIMEOUT_CYC without bus_ack, the FSM SHALL go to DONE and set err and timeout_seen; userData_in SHALL be left unchanged and addr SHALL NOT be incremented.
- When not defined: no counter SHALL be present, BUS SHALL wait indefinitely for bus_ack, and timeout_seen SHALL read 0.

Verification
REQ-020 SETADDR 0x100, then WRITE 0xDEADBEEF with bus_ack one cycle later -> one bus_req with bus_we = 1, bus_addr = 0x100, bus_wdata = 0xDEADBEEF; busy = 0 afterwards; err = 0.
REQ-021 SETADDR 0x200, then READ_INC twice with bus_rdata = 0x11 then 0x22 -> bus_addr = 0x200 then 0x204; userData_in = 0x22 at the end; addr = 0x208.
REQ-022 SETADDR 0xFFFFFFFC, then WRITE_INC -> addr = 0x00000000.
REQ-023 READ with bus_ack held low (macro defined, TIMEOUT_CYC = 8) -> bus_req drops 8 cycles after the BUS state is entered; STATUS returns bit 30 = 1 and bit 28 = 1; CLRERR then clears err.
REQ-024 A second userOp_ready edge while bus_ack is stalled -> the second command is ignored, ovr = 1, and exactly one bus transaction occurs.
REQ-025 trst pulled low 2 cycles into BUS -> bus_req = 0 and busy = 0 immediately; the FSM is in IDLE; a following STATUS returns 0x00000000.
